spi_host_master: RTL and testbench
==================================

Name: spi_host_master

Overview:
- SPI initiator for the accelerator's slave data path; drives the other end of the same link.
- Accepts one command per frame over a valid/ready handshake and generates cs_n, sclk and mosi[3:0] for 1-, 2- or 4-lane operation.
- Frame layout: 20-bit address, 4-bit status, turnaround, then a 16-bit data phase. The data phase is a write on mosi or a read captured from miso.
- Returns read data and completion on a one-cycle response strobe. Sits between the host bus bridge and the SPI pads.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 4..255, because the slave resynchronizes sclk through 3 flops.
- CS_SETUP, 2, clk cycles from cs_n falling to the first sclk rising edge.
- CS_HOLD, 2, clk cycles from the last sclk falling edge to cs_n rising.
- GAP, 4, minimum clk cycles cs_n stays high between frames.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_addr  in  20  frame address
- cmd_status  in  4  status nibble; bit2=1 write, bit2=0 read
- cmd_wdata  in  16  write data
- cmd_mode  in  2  01 single, 10 dual, 11 quad, 00 illegal
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data, valid with rsp_valid
- rsp_err  out  1  illegal mode, valid with rsp_valid
- busy  out  1  frame in progress
- sclk  out  1  serial clock, idle low
- cs_n  out  1  chip select, active low
- mosi  out  4  serial data out
- miso  in  4  serial data in

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk. Reset values: cs_n=1, sclk=0, mosi=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- cmd_ready=1 only in IDLE. On the accept cycle the block latches addr, status, wdata and mode, and sets lanes L = 1, 2 or 4.
- Illegal mode 00: accepted, no frame generated; next cycle rsp_valid=1 with rsp_err=1 and rsp_rdata=0; block stays in IDLE.
- FSM: IDLE -> SETUP -> ADDR -> STAT -> TURN -> DATA -> HOLD -> GAP -> IDLE.
- SETUP: cs_n=0, sclk=0 for CS_SETUP cycles; mosi carries the first address bits.
- Bit-time counter advances by L per sclk period.
  - ADDR: 20 bits.
  - STAT: 4 bits.
  - TURN: 8 bits, mosi=0.
  - DATA: 16 bits.
  - Total 48 bits, i.e. 48/L sclk periods.
- Each sclk period is CLK_DIV cycles low followed by CLK_DIV cycles high.
- mosi update: at the start of each low phase (sclk falling), mosi[k] = field[i+k] for k<L, LSB first. Lanes k>=L are driven 0. Fields are sent in order addr, status, wdata.
- Read frames (status[2]=0): mosi=0 during DATA.
- miso sampling: on the last clk cycle of each DATA high phase, the block captures miso[k] into rdata[i+k] for k<L. Write frames ignore miso.
- HOLD: after the last falling edge, sclk=0 and cs_n=0 for CS_HOLD cycles. Then cs_n=1, and rsp_valid pulses with the captured rdata (0 for writes) and rsp_err=0.
- GAP: cs_n=1 for GAP cycles, then IDLE.
- busy=1 from SETUP through GAP inclusive.
- cmd_valid dropping mid-frame has no effect; the frame completes.
- status[1] is transmitted as given, but the frame always ends after one data phase.
- Any bit-counter wrap is forbidden; DATA ends exactly at bit 16.
- Asserting reset mid-frame forces cs_n=1 and sclk=0 immediately; no rsp_valid is issued.

Optional Feature:
- Macro SPI_HOST_MASTER_MISO_SYNC_EN.
- Defined: miso passes through a 2-flop synchronizer, and the DATA sample point moves to clk cycle 2 of the following low phase. HOLD starts after that final sample.
- Undefined: miso is sampled directly at the last cycle of the high phase as above.
- Bit ordering and all other timing are identical in both builds.

Test Plan:
- Single-lane write, addr=0x12345, status=0x4, wdata=0xA5C3, CLK_DIV=4 -> 48 sclk periods. The slave model decodes addr 0x12345, status 0x4, wdata 0xA5C3. rsp_valid pulses once with rsp_err=0.
- Quad-lane read, addr=0x0000F, status=0x0, slave miso returns 0xBEEF -> 12 sclk periods. mosi=0 in TURN and DATA. rsp_rdata=0xBEEF.
- Dual-lane read, slave returns 0x8001 -> 24 sclk periods; rsp_rdata=0x8001, proving LSB-first lane mapping.
- cmd_mode=00 -> no cs_n activity; rsp_valid and rsp_err both 1 on the cycle after accept; cmd_ready returns to 1 the next cycle.
- Two back-to-back commands with cmd_valid held high -> cs_n high for at least GAP+1 cycles between frames; cmd_ready=0 throughout the first frame.
- reset_n asserted at bit 10 of ADDR -> cs_n=1 and sclk=0 immediately; no rsp_valid. A new command after release produces a complete, correct frame.

Source files
------------

// File: rtl/spi_host_master.sv
// spi_host_master: SPI initiator issuing one addr/status/turn/data frame per command
// (20-bit address, 4-bit status, 8-bit turnaround, 16-bit data) over 1, 2 or 4 lanes.
// Latency: a frame takes CS_SETUP + (48/L)*2*CLK_DIV + CS_HOLD cycles.
//   rsp_valid pulses as cs_n rises.
// Backpressure: cmd_ready is high only while idle, so each command waits for the
//   previous frame's GAP. The response has no ready; it is a one-cycle strobe.
// Ports: clk/reset_n (async, active-low);
//   cmd_* is the valid/ready command (mode 01/10/11 = 1/2/4 lanes, 00 = error);
//   rsp_* is the completion strobe; busy is high while a frame is in flight;
//   sclk/cs_n/mosi/miso go to the SPI pads.
// Optional build macro SPI_HOST_MASTER_MISO_SYNC_EN: miso is resynchronised
//   through two flops, and each DATA sample moves to cycle 2 of the next low phase.
module spi_host_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [19:0] cmd_addr,
  input  logic [3:0]  cmd_status,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  cmd_mode,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic [3:0]  mosi,
  input  logic [3:0]  miso
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ADDR, S_STAT, S_TURN, S_DATA, S_HOLD, S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;        // cycles within SETUP/HOLD/GAP, or within an sclk half-period
  logic [5:0]  bit_cnt;    // frame bits already shifted out, 0..48
  logic [2:0]  lanes;      // 1, 2 or 4
  logic        is_write;
  logic [47:0] tx_sr;      // {wdata or 0, turnaround zeros, status, addr}; LSB goes first
  logic [15:0] rx_sr;
  logic [47:0] tx_shift;
  logic [15:0] rx_ins;
  logic [3:0]  lane_mask;
  logic [3:0]  miso_s;
  logic        accept, mode_ok, shifting, half_end, fall, rise, tail;
  logic        sample, data_done;
  logic [5:0]  bit_nxt;

  assign accept   = cmd_valid && cmd_ready;
  assign mode_ok  = (cmd_mode != 2'b00);
  assign shifting = (state == S_ADDR) || (state == S_STAT) ||
                    (state == S_TURN) || (state == S_DATA);
  assign half_end = shifting && (cnt == DIV_LAST);
  assign fall     = half_end && sclk;
  // Once all 48 bits are out, sclk must stay low. With the synchroniser, DATA
  // lingers briefly in that final low phase to take its last sample.
  assign tail     = (bit_cnt == 6'd48);
  assign rise     = half_end && !sclk && !tail;
  assign bit_nxt  = bit_cnt + {3'b000, lanes};

`ifdef SPI_HOST_MASTER_MISO_SYNC_EN
  logic [3:0] miso_m;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_m <= 4'h0;
      miso_s <= 4'h0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  // Cycle 2 of a low phase sees, through the two flops, what miso held at the end
  // of the preceding high phase. The first DATA low phase follows a TURN bit,
  // so it is skipped.
  assign sample    = (state == S_DATA) && !sclk && (cnt == 8'd1) && (bit_cnt != 6'd32);
  assign data_done = (state == S_DATA) && !sclk && (cnt == 8'd1) && tail;
`else
  assign miso_s    = miso;
  assign sample    = (state == S_DATA) && fall;
  assign data_done = (state == S_DATA) && fall && (bit_nxt == 6'd48);
`endif

  always_comb begin
    tx_shift  = tx_sr >> 1;
    rx_ins    = {miso_s[0], rx_sr[15:1]};
    lane_mask = 4'b0001;
    case (lanes)
      3'd2: begin
        tx_shift  = tx_sr >> 2;
        rx_ins    = {miso_s[1:0], rx_sr[15:2]};
        lane_mask = 4'b0011;
      end
      3'd4: begin
        tx_shift  = tx_sr >> 4;
        rx_ins    = {miso_s, rx_sr[15:4]};
        lane_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  // tx_sr only moves on sclk falling edges, so mosi changes at the start of each
  // low phase. Read frames and the turnaround load zeros, and tx_sr is fully
  // shifted out by the end of a frame, so mosi is 0 when idle.
  assign mosi = tx_sr[3:0] & lane_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && mode_ok)           state_nxt = S_SETUP;
      S_SETUP: if (cnt == SETUP_LAST)           state_nxt = S_ADDR;
      S_ADDR:  if (fall && bit_nxt == 6'd20)    state_nxt = S_STAT;
      S_STAT:  if (fall && bit_nxt == 6'd24)    state_nxt = S_TURN;
      S_TURN:  if (fall && bit_nxt == 6'd32)    state_nxt = S_DATA;
      S_DATA:  if (data_done)                   state_nxt = S_HOLD;
      S_HOLD:  if (cnt == HOLD_LAST)            state_nxt = S_GAP;
      S_GAP:   if (cnt == GAP_LAST)             state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 8'd0;
      bit_cnt   <= 6'd0;
      lanes     <= 3'd1;
      is_write  <= 1'b0;
      tx_sr     <= 48'd0;
      rx_sr     <= 16'd0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      if (state_nxt != state || half_end) cnt <= 8'd0;
      else if (state != S_IDLE)           cnt <= cnt + 8'd1;

      if (rise)      sclk <= 1'b1;
      else if (fall) sclk <= 1'b0;

      if (accept) begin
        bit_cnt <= 6'd0;
        rx_sr   <= 16'd0;
        if (mode_ok) begin
          lanes    <= (cmd_mode == 2'b11) ? 3'd4 : (cmd_mode == 2'b10) ? 3'd2 : 3'd1;
          is_write <= cmd_status[2];
          tx_sr    <= {(cmd_status[2] ? cmd_wdata : 16'h0000), 8'h00, cmd_status, cmd_addr};
        end
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        tx_sr   <= tx_shift;
      end

      if (sample && !is_write) rx_sr <= rx_ins;

      cs_n      <= (state_nxt == S_IDLE) || (state_nxt == S_GAP);
      busy      <= (state_nxt != S_IDLE);
      // Held low on the cycle after any accept, including an illegal-mode one.
      cmd_ready <= (state_nxt == S_IDLE) && !accept;

      if (accept && !mode_ok) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= 16'd0;
      end else if (state == S_HOLD && state_nxt == S_GAP) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
module tb_spi_host_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [19:0] cmd_addr = 20'h0;
  logic [3:0]  cmd_status = 4'h0;
  logic [15:0] cmd_wdata = 16'h0;
  logic [1:0]  cmd_mode = 2'b01;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic [3:0]  mosi;
  logic [3:0]  miso = 4'h0;

  always #5 clk = ~clk;

  spi_host_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_status(cmd_status), .cmd_wdata(cmd_wdata), .cmd_mode(cmd_mode),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Slave model: mosi is captured on each sclk rise; miso is driven on each
  // sclk fall with the bits of the next period.
  int          lanes_tb = 1;
  logic [15:0] rdval = 16'h0;
  logic [47:0] cap = 48'h0;
  int          sb = 0;
  int          rises = 0;
  int          cs_falls = 0;
  logic        hi_err = 1'b0;
  logic        cs_q = 1'b1;
  logic        sclk_q = 1'b0;

  always @(cs_n or sclk) begin
    if (cs_q === 1'b1 && cs_n === 1'b0) begin
      sb = 0; cap = 48'h0; rises = 0; hi_err = 1'b0; miso = 4'h0;
      cs_falls = cs_falls + 1;
    end
    if (sclk_q === 1'b0 && sclk === 1'b1 && cs_n === 1'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (k < lanes_tb) begin
          if (sb + k < 48) cap[sb + k] = mosi[k];
        end else if (mosi[k] !== 1'b0) begin
          hi_err = 1'b1;
        end
      end
      sb = sb + lanes_tb;
      rises = rises + 1;
    end
    if (sclk_q === 1'b1 && sclk === 1'b0 && cs_n === 1'b0) begin
      miso = 4'h0;
      if (sb >= 32 && sb < 48)
        for (int k = 0; k < 4; k++)
          if (k < lanes_tb) miso[k] = rdval[sb - 32 + k];
    end
    cs_q = cs_n;
    sclk_q = sclk;
  end

  int rsp_cnt = 0;
  int hi_run = 0;
  int last_hi_run = 0;
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_cnt++;
    if (cs_n === 1'b1) hi_run++;
    else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
  end

  int acc_cnt = 0;
  always @(posedge clk) if (cmd_valid && cmd_ready) acc_cnt++;

  task automatic issue(input logic [19:0] a, input logic [3:0] s,
                       input logic [15:0] w, input logic [1:0] m);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL issue_ready got=%b want=1", cmd_ready); end
    cmd_addr = a; cmd_status = s; cmd_wdata = w; cmd_mode = m; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output logic [15:0] rd, output logic er);
    got = 1'b0; rd = 16'h0; er = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (rsp_valid === 1'b1) begin got = 1'b1; rd = rsp_rdata; er = rsp_err; end
      else @(negedge clk);
    end
    n_chk++;
    if (!got) begin n_bad++; $display("FAIL rsp_timeout got=0 want=1"); end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (cs_n !== 1'b1)       begin n_bad++; $display("FAIL rst_cs_n got=%b want=1", cs_n); end
    n_chk++; if (sclk !== 1'b0)       begin n_bad++; $display("FAIL rst_sclk got=%b want=0", sclk); end
    n_chk++; if (mosi !== 4'h0)       begin n_bad++; $display("FAIL rst_mosi got=%h want=0", mosi); end
    n_chk++; if (cmd_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_cmd_ready got=%b want=0", cmd_ready); end
    n_chk++; if (rsp_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    n_chk++; if (rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL rst_rsp_rdata got=%h want=0", rsp_rdata); end
    n_chk++; if (rsp_err !== 1'b0)    begin n_bad++; $display("FAIL rst_rsp_err got=%b want=0", rsp_err); end
    n_chk++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1)  begin n_bad++; $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_single_write;
    logic got, er; logic [15:0] rd; int r0;
    lanes_tb = 1; rdval = 16'hFFFF; r0 = rsp_cnt;
    issue(20'h12345, 4'h4, 16'hA5C3, 2'b01);
    n_chk++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sw_busy got=%b want=1", busy); end
    wait_rsp(got, rd, er);
    n_chk++; if (er !== 1'b0)            begin n_bad++; $display("FAIL sw_err got=%b want=0", er); end
    n_chk++; if (rd !== 16'h0)           begin n_bad++; $display("FAIL sw_rdata got=%h want=0", rd); end
    n_chk++; if (rises != 48)            begin n_bad++; $display("FAIL sw_periods got=%0d want=48", rises); end
    n_chk++; if (cap[19:0] !== 20'h12345) begin n_bad++; $display("FAIL sw_addr got=%h want=12345", cap[19:0]); end
    n_chk++; if (cap[23:20] !== 4'h4)    begin n_bad++; $display("FAIL sw_status got=%h want=4", cap[23:20]); end
    n_chk++; if (cap[31:24] !== 8'h00)   begin n_bad++; $display("FAIL sw_turn got=%h want=00", cap[31:24]); end
    n_chk++; if (cap[47:32] !== 16'hA5C3) begin n_bad++; $display("FAIL sw_wdata got=%h want=a5c3", cap[47:32]); end
    n_chk++; if (hi_err !== 1'b0)        begin n_bad++; $display("FAIL sw_unused_lanes got=%b want=0", hi_err); end
    repeat (10) @(negedge clk);
    n_chk++; if (rsp_cnt - r0 != 1)      begin n_bad++; $display("FAIL sw_rsp_count got=%0d want=1", rsp_cnt - r0); end
    n_chk++; if (busy !== 1'b0)          begin n_bad++; $display("FAIL sw_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_quad_read;
    logic got, er; logic [15:0] rd;
    lanes_tb = 4; rdval = 16'hBEEF;
    issue(20'h0000F, 4'h0, 16'h1357, 2'b11);
    wait_rsp(got, rd, er);
    n_chk++; if (rd !== 16'hBEEF)        begin n_bad++; $display("FAIL qr_rdata got=%h want=beef", rd); end
    n_chk++; if (er !== 1'b0)            begin n_bad++; $display("FAIL qr_err got=%b want=0", er); end
    n_chk++; if (rises != 12)            begin n_bad++; $display("FAIL qr_periods got=%0d want=12", rises); end
    n_chk++; if (cap[19:0] !== 20'h0000F) begin n_bad++; $display("FAIL qr_addr got=%h want=0000f", cap[19:0]); end
    n_chk++; if (cap[47:24] !== 24'h0)   begin n_bad++; $display("FAIL qr_mosi_turn_data got=%h want=0", cap[47:24]); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_dual_read;
    logic got, er; logic [15:0] rd;
    lanes_tb = 2; rdval = 16'h8001;
    issue(20'h00ABC, 4'h3, 16'hFFFF, 2'b10);
    wait_rsp(got, rd, er);
    n_chk++; if (rd !== 16'h8001)        begin n_bad++; $display("FAIL dr_rdata got=%h want=8001", rd); end
    n_chk++; if (rises != 24)            begin n_bad++; $display("FAIL dr_periods got=%0d want=24", rises); end
    n_chk++; if (cap[23:0] !== 24'h300ABC) begin n_bad++; $display("FAIL dr_addr_status got=%h want=300abc", cap[23:0]); end
    n_chk++; if (cap[47:24] !== 24'h0)   begin n_bad++; $display("FAIL dr_mosi_turn_data got=%h want=0", cap[47:24]); end
    n_chk++; if (hi_err !== 1'b0)        begin n_bad++; $display("FAIL dr_unused_lanes got=%b want=0", hi_err); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_illegal_mode;
    int c0;
    c0 = cs_falls;
    issue(20'h55555, 4'h4, 16'h1111, 2'b00);
    n_chk++; if (rsp_valid !== 1'b1)  begin n_bad++; $display("FAIL il_rsp_valid got=%b want=1", rsp_valid); end
    n_chk++; if (rsp_err !== 1'b1)    begin n_bad++; $display("FAIL il_rsp_err got=%b want=1", rsp_err); end
    n_chk++; if (rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL il_rsp_rdata got=%h want=0", rsp_rdata); end
    n_chk++; if (cmd_ready !== 1'b0)  begin n_bad++; $display("FAIL il_ready_low got=%b want=0", cmd_ready); end
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1)  begin n_bad++; $display("FAIL il_ready_back got=%b want=1", cmd_ready); end
    n_chk++; if (rsp_valid !== 1'b0)  begin n_bad++; $display("FAIL il_rsp_once got=%b want=0", rsp_valid); end
    repeat (4) @(negedge clk);
    n_chk++; if (cs_falls != c0)      begin n_bad++; $display("FAIL il_cs_activity got=%0d want=%0d", cs_falls, c0); end
    n_chk++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL il_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    logic got, er, got_a; logic [15:0] rd, rd_a; int a0, r0, viol, n;
    lanes_tb = 4; rdval = 16'h5A5A;
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    a0 = acc_cnt; r0 = rsp_cnt;
    cmd_addr = 20'h00001; cmd_status = 4'h1; cmd_wdata = 16'h0; cmd_mode = 2'b11; cmd_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (acc_cnt == a0 && n < 1000);
    cmd_addr = 20'hABCDE; cmd_status = 4'h6; cmd_wdata = 16'h1234;
    viol = 0; got_a = 1'b0; rd_a = 16'h0; n = 0;
    while (acc_cnt < a0 + 2 && n < 3000) begin
      if (!got_a && cmd_ready === 1'b1) viol++;
      if (rsp_valid === 1'b1 && !got_a) begin got_a = 1'b1; rd_a = rsp_rdata; end
      @(negedge clk); n++;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (acc_cnt != a0 + 2)   begin n_bad++; $display("FAIL b2b_accepts got=%0d want=%0d", acc_cnt - a0, 2); end
    n_chk++; if (viol != 0)           begin n_bad++; $display("FAIL b2b_ready_in_frame got=%0d want=0", viol); end
    n_chk++; if (rd_a !== 16'h5A5A)   begin n_bad++; $display("FAIL b2b_rdata_a got=%h want=5a5a", rd_a); end
    n_chk++; if (last_hi_run < 5)     begin n_bad++; $display("FAIL b2b_gap got=%0d want>=5", last_hi_run); end
    wait_rsp(got, rd, er);
    n_chk++; if (rd !== 16'h0)        begin n_bad++; $display("FAIL b2b_rdata_b got=%h want=0", rd); end
    n_chk++; if (cap[23:0] !== 24'h6ABCDE) begin n_bad++; $display("FAIL b2b_addr_b got=%h want=6abcde", cap[23:0]); end
    n_chk++; if (cap[47:32] !== 16'h1234) begin n_bad++; $display("FAIL b2b_wdata_b got=%h want=1234", cap[47:32]); end
    repeat (8) @(negedge clk);
    n_chk++; if (rsp_cnt - r0 != 2)   begin n_bad++; $display("FAIL b2b_rsp_count got=%0d want=2", rsp_cnt - r0); end
  endtask

  task automatic test_reset_mid_frame;
    logic got, er; logic [15:0] rd; int r0, n;
    lanes_tb = 1; rdval = 16'h0;
    issue(20'hFFFFF, 4'h4, 16'hFFFF, 2'b01);
    n = 0;
    while (sb < 10 && n < 2000) begin @(negedge clk); n++; end
    n_chk++; if (sb < 10) begin n_bad++; $display("FAIL rm_reach_bit10 got=%0d want=10", sb); end
    r0 = rsp_cnt;
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL rm_cs_n got=%b want=1", cs_n); end
    n_chk++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL rm_sclk got=%b want=0", sclk); end
    n_chk++; if (mosi !== 4'h0) begin n_bad++; $display("FAIL rm_mosi got=%h want=0", mosi); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++; if (rsp_cnt != r0) begin n_bad++; $display("FAIL rm_no_rsp got=%0d want=%0d", rsp_cnt, r0); end
    lanes_tb = 2;
    issue(20'h0F0F0, 4'h5, 16'h3C3C, 2'b10);
    wait_rsp(got, rd, er);
    n_chk++; if (er !== 1'b0)          begin n_bad++; $display("FAIL rm_err got=%b want=0", er); end
    n_chk++; if (rises != 24)          begin n_bad++; $display("FAIL rm_periods got=%0d want=24", rises); end
    n_chk++; if (cap[23:0] !== 24'h50F0F0) begin n_bad++; $display("FAIL rm_addr_status got=%h want=50f0f0", cap[23:0]); end
    n_chk++; if (cap[47:32] !== 16'h3C3C) begin n_bad++; $display("FAIL rm_wdata got=%h want=3c3c", cap[47:32]); end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_quad_read;
    test_dual_read;
    test_illegal_mode;
    test_back_to_back;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
